// File: rtl/drive_arbiter_pkg.sv
// Shared types for the drive arbiter: direction codes, modes, FSM states,
// manual flag bit positions and small helper functions.
package drive_pkg;

    typedef enum logic [3:0] {
        DIR_STOP = 4'd0,
        DIR_W    = 4'd1,
        DIR_A    = 4'd2,
        DIR_S    = 4'd3,
        DIR_D    = 4'd4,
        DIR_WA   = 4'd5,
        DIR_WD   = 4'd6,
        DIR_AS   = 4'd7,
        DIR_AD   = 4'd8
    } dir_t;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_AUTO   = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    // Bit positions inside man_flags = {stop,ad,as,wd,wa,d,s,a,w}
    localparam int MAN_FLAGS_W = 9;
    localparam int FLAG_W      = 0;
    localparam int FLAG_A      = 1;
    localparam int FLAG_S      = 2;
    localparam int FLAG_D      = 3;
    localparam int FLAG_WA     = 4;
    localparam int FLAG_WD     = 5;
    localparam int FLAG_AS     = 6;
    localparam int FLAG_AD     = 7;
    localparam int FLAG_STOP   = 8;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic dir_t to_dir(input logic [3:0] code);
        return (code > 4'd8) ? DIR_STOP : dir_t'(code);
    endfunction

endpackage

// File: rtl/drive_arbiter_if.sv
// Bundle of the arbiter's mode/command inputs and motor-side outputs.
// The arbiter uses the slave modport; the upstream/test side uses master.
interface drive_arbiter_if;
    import drive_pkg::*;

    logic                   manual_on;
    logic                   auto_on;
    logic [MAN_FLAGS_W-1:0] man_flags;
    logic [3:0]             auto_dir;
    logic                   auto_valid;
    logic                   auto_ready;
    dir_t                   drive_dir;
    logic                   drive_update;
    mode_t                  active_mode;
    logic                   wd_trip;

    modport slave (
        input  manual_on, auto_on, man_flags, auto_dir, auto_valid,
        output auto_ready, drive_dir, drive_update, active_mode, wd_trip
    );

    modport master (
        output manual_on, auto_on, man_flags, auto_dir, auto_valid,
        input  auto_ready, drive_dir, drive_update, active_mode, wd_trip
    );

endinterface

// File: rtl/drive_arbiter_dir_encoder.sv
// Combinational one-hot manual flag decoder; anything but exactly one
// direction flag (including the stop flag alone) yields STOP.
module dir_encoder
    import drive_pkg::*;
(
    input  logic [MAN_FLAGS_W-1:0] i_flags,
    output dir_t                   o_dir
);

    localparam logic [MAN_FLAGS_W-1:0] ONE = MAN_FLAGS_W'(1);

    always_comb begin
        o_dir = DIR_STOP;
        case (i_flags)
            ONE << FLAG_W:  o_dir = DIR_W;
            ONE << FLAG_A:  o_dir = DIR_A;
            ONE << FLAG_S:  o_dir = DIR_S;
            ONE << FLAG_D:  o_dir = DIR_D;
            ONE << FLAG_WA: o_dir = DIR_WA;
            ONE << FLAG_WD: o_dir = DIR_WD;
            ONE << FLAG_AS: o_dir = DIR_AS;
            ONE << FLAG_AD: o_dir = DIR_AD;
            default:        o_dir = DIR_STOP;
        endcase
    end

endmodule

// File: rtl/drive_arbiter.sv
// Motor direction arbiter: chooses manual or autonomous commands with a timed
// STOP dwell on every mode change. Optional auto watchdog: DRIVE_WATCHDOG_EN.
module drive_arbiter
    import drive_pkg::*;
#(
    parameter int DWELL_CYCLES   = 2_500_000,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    drive_arbiter_if.slave  bus
);

    localparam int                 DWELL_W    = cnt_w(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("DWELL_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t             r_state, w_state_nxt;
    mode_t              r_active_mode, w_mode_nxt;
    mode_t              r_sw_target, w_sw_target_nxt;
    mode_t              w_target;
    dir_t               r_drive_dir, w_dir_nxt, w_man_dir;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic               r_auto_ready, w_auto_ready_nxt;
    logic               r_drive_update;
    logic               r_wd_trip, w_wd_trip_nxt;
    logic               w_mode_change;
    logic               w_accept;
    logic               w_wd_fire;

    dir_encoder u_dir_encoder (
        .i_flags (bus.man_flags),
        .o_dir   (w_man_dir)
    );

    // Both requests high is a conflict and resolves to NONE.
    always_comb begin
        w_target = MODE_NONE;
        if (bus.manual_on && !bus.auto_on)
            w_target = MODE_MANUAL;
        else if (bus.auto_on && !bus.manual_on)
            w_target = MODE_AUTO;
    end

    assign w_mode_change = (r_state != ST_SWITCH) && (w_target != r_active_mode);
    assign w_accept      = r_auto_ready && bus.auto_valid;

`ifdef DRIVE_WATCHDOG_EN
    localparam int              WD_W    = cnt_w(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wd_tripped;

    assign w_wd_fire = (r_state == ST_AUTO) && !r_wd_tripped && !w_accept &&
                       (r_wd_cnt == WD_LAST);

    // Held at zero outside AUTO, so entering AUTO always starts a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt     <= '0;
            r_wd_tripped <= 1'b0;
        end else if ((r_state != ST_AUTO) || w_accept) begin
            r_wd_cnt     <= '0;
            r_wd_tripped <= 1'b0;
        end else if (r_wd_cnt == WD_LAST) begin
            r_wd_tripped <= 1'b1;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_active_mode  <= MODE_NONE;
            r_sw_target    <= MODE_NONE;
            r_drive_dir    <= DIR_STOP;
            r_dwell        <= '0;
            r_auto_ready   <= 1'b0;
            r_drive_update <= 1'b0;
            r_wd_trip      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_active_mode  <= w_mode_nxt;
            r_sw_target    <= w_sw_target_nxt;
            r_drive_dir    <= w_dir_nxt;
            r_dwell        <= w_dwell_nxt;
            r_auto_ready   <= w_auto_ready_nxt;
            r_drive_update <= (w_dir_nxt != r_drive_dir);
            r_wd_trip      <= w_wd_trip_nxt;
        end
    end

    // The dwell tracks the target it was started for; any change restarts it.
    always_comb begin
        w_state_nxt     = r_state;
        w_dwell_nxt     = r_dwell;
        w_sw_target_nxt = r_sw_target;
        case (r_state)
            ST_SWITCH: begin
                if (w_target != r_sw_target) begin
                    w_dwell_nxt     = '0;
                    w_sw_target_nxt = w_target;
                end else if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    case (r_sw_target)
                        MODE_MANUAL: w_state_nxt = ST_MANUAL;
                        MODE_AUTO:   w_state_nxt = ST_AUTO;
                        default:     w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            default: begin
                if (w_mode_change) begin
                    w_state_nxt     = ST_SWITCH;
                    w_dwell_nxt     = '0;
                    w_sw_target_nxt = w_target;
                end
            end
        endcase
    end

    always_comb begin
        w_dir_nxt        = r_drive_dir;
        w_wd_trip_nxt    = 1'b0;
        w_auto_ready_nxt = (w_state_nxt == ST_AUTO);
        case (w_state_nxt)
            ST_MANUAL: w_mode_nxt = MODE_MANUAL;
            ST_AUTO:   w_mode_nxt = MODE_AUTO;
            default:   w_mode_nxt = MODE_NONE;
        endcase
        case (r_state)
            ST_MANUAL: begin
                w_dir_nxt = w_mode_change ? DIR_STOP : w_man_dir;
            end
            ST_AUTO: begin
                if (w_mode_change) begin
                    w_dir_nxt = DIR_STOP;
                end else if (w_accept) begin
                    w_dir_nxt = to_dir(bus.auto_dir);
                end else if (w_wd_fire) begin
                    w_dir_nxt     = DIR_STOP;
                    w_wd_trip_nxt = 1'b1;
                end
            end
            default: begin
                w_dir_nxt = DIR_STOP;
            end
        endcase
    end

    assign bus.auto_ready   = r_auto_ready;
    assign bus.drive_dir    = r_drive_dir;
    assign bus.drive_update = r_drive_update;
    assign bus.active_mode  = r_active_mode;
    assign bus.wd_trip      = r_wd_trip;

endmodule
